// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-lite response codes, protection bit index and slave FSM states
package axi_lite_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;
  localparam int PROT_INSTR = 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_WAIT,
    S_WR_RESP
  } slave_state_e;
endpackage

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: single-port synchronous word array with per-byte write enables
module sram_1rw_be #(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI4-lite slave memory for fetch, load and strobed store with fixed response latency
module axi_lite_sram
  import axi_lite_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter int    LATENCY    = 1,
  parameter int    ROM_WORDS  = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddress,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddress,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);
  slave_state_e state;
  logic [3:0]  cnt;
  logic        is_wr;
  logic        done;
  logic [31:0] addr;
  logic [31:0] data;
  logic [3:0]  strb;
  logic [2:0]  prot;
  logic [31:0] q;
  logic        misalign;
  logic        out_of_range;
  logic        rom_hit;
  logic        we;
  resp_t       resp;
  logic        unused_ok;
  assign unused_ok    = ^{bvalid, prot[1:0]};
  assign misalign     = |addr[1:0];
  assign out_of_range = |addr[31:DEPTH_LOG2+2];
  // word index + 1 <= ROM_WORDS avoids a constant compare when ROM_WORDS is 0
  assign rom_hit      = is_wr && !prot[PROT_INSTR] && ({1'b0, addr[31:2]} + 31'd1 <= 31'(ROM_WORDS));
  assign resp         = (misalign || out_of_range || rom_hit) ? RESP_SLVERR : RESP_OKAY;
  // commit only on the first response cycle, and never at an edge where reset is asserted
  assign we           = reset && state == S_WR_RESP && !done && resp == RESP_OKAY;
  assign rvalid       = state == S_RD_RESP;
  assign arready      = rvalid;
  assign rresp        = rvalid ? resp : RESP_OKAY;
  assign rdata        = (rvalid && resp == RESP_OKAY) ? q : '0;
  assign bready       = state == S_WR_RESP;
  assign awready      = bready;
  assign wready       = bready;
  assign bresp        = bready ? resp : RESP_OKAY;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      is_wr <= 1'b0;
      done  <= 1'b0;
      addr  <= '0;
      data  <= '0;
      strb  <= '0;
      prot  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (arvalid && rready) begin
            state <= S_RD_WAIT;
            cnt   <= 4'(LATENCY - 1);
            is_wr <= 1'b0;
            addr  <= araddress;
            prot  <= arprot;
          end else if (awvalid && wvalid) begin
            state <= S_WR_WAIT;
            cnt   <= 4'(LATENCY - 1);
            is_wr <= 1'b1;
            done  <= 1'b0;
            addr  <= awaddress;
            prot  <= awprot;
            data  <= wdata;
            strb  <= wstrb;
          end
        S_RD_WAIT:
          if (cnt == '0) state <= S_RD_RESP;
          else cnt <= cnt - 4'd1;
        S_RD_RESP:
          if (!arvalid) state <= S_IDLE;
        S_WR_WAIT:
          if (cnt == '0) state <= S_WR_RESP;
          else cnt <= cnt - 4'd1;
        S_WR_RESP: begin
          done <= 1'b1;
          if (!awvalid && !wvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  sram_1rw_be #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .be   (strb),
    .addr (addr[DEPTH_LOG2+1:2]),
    .wdata(data),
    .rdata(q)
  );
endmodule
